ex_operand_stage: RTL and testbench



---
 rtl/ex_operand_stage.sv | 106 ++++++++++
 tb/tb_ex_operand_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// Execute-entry operand stage: forwards results, selects BusB, and registers the ALU operands.
// Optional feature macro FORWARDING_EN enables forwarding and the load-use stall.
`timescale 1ns/1ps
module ex_operand_stage #(
    parameter logic [4:0] XZR    = 5'd31,
    parameter int         STALLW = 16
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_RegA,
    input  logic [63:0]       in_RegB,
    input  logic [4:0]        in_Rn,
    input  logic [4:0]        in_Rm,
    input  logic [4:0]        in_Rd,
    input  logic [63:0]       in_Imm,
    input  logic              in_ALUSrc,
    input  logic [3:0]        in_ALUCtrl,
    input  logic              in_RegWrite,
    input  logic              flush,
    input  logic [4:0]        fwd1_Rd,
    input  logic              fwd1_RegWrite,
    input  logic              fwd1_IsLoad,
    input  logic [63:0]       fwd1_Result,
    input  logic [4:0]        fwd2_Rd,
    input  logic              fwd2_RegWrite,
    input  logic [63:0]       fwd2_Result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       BusA,
    output logic [63:0]       BusB,
    output logic [3:0]        ALUCtrl,
    output logic [63:0]       out_StoreData,
    output logic [4:0]        out_Rd,
    output logic              out_RegWrite,
    output logic [STALLW-1:0] stall_count
);

    logic [63:0] fwdA;
    logic [63:0] fwdB;
    logic        hazard;
    logic        capture;

`ifdef FORWARDING_EN
    logic matchA1, matchA2, matchB1, matchB2;

    always_comb begin
        matchA1 = fwd1_RegWrite && (fwd1_Rd == in_Rn) && (in_Rn != XZR);
        matchA2 = fwd2_RegWrite && (fwd2_Rd == in_Rn) && (in_Rn != XZR);
        matchB1 = fwd1_RegWrite && (fwd1_Rd == in_Rm) && (in_Rm != XZR);
        matchB2 = fwd2_RegWrite && (fwd2_Rd == in_Rm) && (in_Rm != XZR);
        fwdA    = matchA1 ? fwd1_Result : (matchA2 ? fwd2_Result : in_RegA);
        fwdB    = matchB1 ? fwd1_Result : (matchB2 ? fwd2_Result : in_RegB);
        // Rm is checked even for immediate forms: stores still need its value.
        hazard  = in_valid && fwd1_IsLoad && (matchA1 || matchB1);
    end
`else
    logic unusedFwd;
    assign unusedFwd = ^{in_Rn, in_Rm, fwd1_Rd, fwd1_RegWrite, fwd1_IsLoad, fwd1_Result,
                         fwd2_Rd, fwd2_RegWrite, fwd2_Result};
    assign fwdA   = in_RegA;
    assign fwdB   = in_RegB;
    assign hazard = 1'b0;
`endif

    // Handshake: a beat transfers on a side only in a cycle where valid and ready are both
    // high; out_valid holds with stable data until out_ready, and in_ready never looks at in_valid
    // except through the load-use hazard term.
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            out_valid     <= 1'b0;
            out_RegWrite  <= 1'b0;
            BusA          <= '0;
            BusB          <= '0;
            out_StoreData <= '0;
            ALUCtrl       <= 4'b0000;
            out_Rd        <= XZR;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_RegWrite <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            BusA          <= fwdA;
            BusB          <= in_ALUSrc ? in_Imm : fwdB;
            out_StoreData <= fwdB;
            ALUCtrl       <= in_ALUCtrl;
            out_Rd        <= in_Rd;
            out_RegWrite  <= in_RegWrite;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            stall_count <= '0;
        end else if (hazard && in_valid && (stall_count != '1)) begin
            stall_count <= stall_count + STALLW'(1);
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Table-driven bench for ex_operand_stage; expectations follow FORWARDING_EN when it is defined.
`timescale 1ns/1ps
module tb_ex_operand_stage;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK, resetl;
    logic        in_valid, in_ready;
    logic [63:0] in_RegA, in_RegB, in_Imm;
    logic [4:0]  in_Rn, in_Rm, in_Rd;
    logic        in_ALUSrc, in_RegWrite, flush;
    logic [3:0]  in_ALUCtrl;
    logic [4:0]  fwd1_Rd, fwd2_Rd;
    logic        fwd1_RegWrite, fwd1_IsLoad, fwd2_RegWrite;
    logic [63:0] fwd1_Result, fwd2_Result;
    logic        out_valid, out_ready;
    logic [63:0] BusA, BusB, out_StoreData;
    logic [3:0]  ALUCtrl;
    logic [4:0]  out_Rd;
    logic        out_RegWrite;
    logic [15:0] stall_count;

    ex_operand_stage #(.XZR(5'd31), .STALLW(16)) dut (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_RegA(in_RegA), .in_RegB(in_RegB),
        .in_Rn(in_Rn), .in_Rm(in_Rm), .in_Rd(in_Rd),
        .in_Imm(in_Imm), .in_ALUSrc(in_ALUSrc), .in_ALUCtrl(in_ALUCtrl),
        .in_RegWrite(in_RegWrite), .flush(flush),
        .fwd1_Rd(fwd1_Rd), .fwd1_RegWrite(fwd1_RegWrite), .fwd1_IsLoad(fwd1_IsLoad),
        .fwd1_Result(fwd1_Result),
        .fwd2_Rd(fwd2_Rd), .fwd2_RegWrite(fwd2_RegWrite), .fwd2_Result(fwd2_Result),
        .out_valid(out_valid), .out_ready(out_ready),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .out_StoreData(out_StoreData),
        .out_Rd(out_Rd), .out_RegWrite(out_RegWrite), .stall_count(stall_count)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        valid, aluSrc, regWrite, flush, f1We, f1Ld, f2We, outReady;
        logic [63:0] regA, regB, imm, f1Res, f2Res;
        logic [4:0]  rn, rm, rd, f1Rd, f2Rd;
        logic [3:0]  ctrl;
        logic        eInReady, eValid, chkData, eRw;
        logic [63:0] eA, eB, eS;
        logic [3:0]  eCtrl;
        logic [4:0]  eRd;
        logic [15:0] eStall;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];
    logic [63:0] exp_q[$];
    int nChecks = 0;
    int nErrors = 0;

    function automatic vec_t blank();
        vec_t v;
        v.valid = 0; v.aluSrc = 0; v.regWrite = 0; v.flush = 0;
        v.f1We = 0; v.f1Ld = 0; v.f2We = 0; v.outReady = 1;
        v.regA = 0; v.regB = 0; v.imm = 0; v.f1Res = 0; v.f2Res = 0;
        v.rn = 0; v.rm = 0; v.rd = 0; v.f1Rd = 0; v.f2Rd = 0; v.ctrl = 0;
        v.eInReady = 1; v.eValid = 0; v.chkData = 1; v.eRw = 0;
        v.eA = 0; v.eB = 0; v.eS = 0; v.eCtrl = 0; v.eRd = 0; v.eStall = 0;
        return v;
    endfunction

    function automatic vec_t setExp(vec_t v, logic inR, logic ov, logic [63:0] a, logic [63:0] b,
                                    logic [63:0] s, logic [3:0] c, logic [4:0] rd, logic rw,
                                    logic [15:0] st);
        v.eInReady = inR; v.eValid = ov; v.eA = a; v.eB = b; v.eS = s;
        v.eCtrl = c; v.eRd = rd; v.eRw = rw; v.eStall = st;
        return v;
    endfunction

    // Driver tasks
    task automatic drive(input vec_t v);
        in_valid = v.valid; in_RegA = v.regA; in_RegB = v.regB; in_Imm = v.imm;
        in_Rn = v.rn; in_Rm = v.rm; in_Rd = v.rd; in_ALUSrc = v.aluSrc;
        in_ALUCtrl = v.ctrl; in_RegWrite = v.regWrite; flush = v.flush;
        fwd1_Rd = v.f1Rd; fwd1_RegWrite = v.f1We; fwd1_IsLoad = v.f1Ld; fwd1_Result = v.f1Res;
        fwd2_Rd = v.f2Rd; fwd2_RegWrite = v.f2We; fwd2_Result = v.f2Res;
        out_ready = v.outReady;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_RegWrite"}, 64'(out_RegWrite), 64'd0);
        check({tag, " BusA"}, BusA, 64'd0);
        check({tag, " BusB"}, BusB, 64'd0);
        check({tag, " out_StoreData"}, out_StoreData, 64'd0);
        check({tag, " ALUCtrl"}, 64'(ALUCtrl), 64'd0);
        check({tag, " out_Rd"}, 64'(out_Rd), 64'd31);
        check({tag, " stall_count"}, 64'(stall_count), 64'd0);
    endtask

    initial begin
        vec_t v;
        // Row 0: plain ADD right after reset release.
        v = blank(); v.valid = 1; v.regA = 5; v.regB = 7; v.rn = 1; v.rm = 2; v.rd = 3; v.ctrl = 4'b0010; v.regWrite = 1;
        tbl[0] = setExp(v, 1, 1, 5, 7, 7, 4'b0010, 3, 1, 0);
        // Rows 1-3: forwarding priority fwd1 > fwd2 > regfile, XZR never forwarded.
        v = blank(); v.valid = 1; v.rn = 3; v.rm = 5; v.regA = 'h33; v.regB = 'h44; v.rd = 6; v.regWrite = 1;
        v.f1Rd = 3; v.f1We = 1; v.f1Res = 'h11; v.f2Rd = 3; v.f2We = 1; v.f2Res = 'h22;
        tbl[1] = setExp(v, 1, 1, FWD ? 64'h11 : 64'h33, 'h44, 'h44, 0, 6, 1, 0);
        v.f1We = 0;
        tbl[2] = setExp(v, 1, 1, FWD ? 64'h22 : 64'h33, 'h44, 'h44, 0, 6, 1, 0);
        v.rn = 31; v.rm = 31; v.f1Rd = 31; v.f1We = 1; v.f2Rd = 31; v.ctrl = 4'b0001;
        tbl[3] = setExp(v, 1, 1, 'h33, 'h44, 'h44, 4'b0001, 6, 1, 0);
        // Row 4: Rm from a non-load fwd1, Rn from fwd2.
        v = blank(); v.valid = 1; v.rn = 7; v.rm = 8; v.regA = 'h70; v.regB = 'h80; v.rd = 10; v.ctrl = 4'b0010; v.regWrite = 1;
        v.f1Rd = 8; v.f1We = 1; v.f1Res = 'h99; v.f2Rd = 7; v.f2We = 1; v.f2Res = 'h77;
        tbl[4] = setExp(v, 1, 1, FWD ? 64'h77 : 64'h70, FWD ? 64'h99 : 64'h80, FWD ? 64'h99 : 64'h80, 4'b0010, 10, 1, 0);
        // Rows 5-6: load-use on Rm, one bubble, then capture with the load data.
        v = blank(); v.valid = 1; v.rn = 1; v.rm = 4; v.regA = 'h10; v.regB = 'h40; v.rd = 9; v.ctrl = 4'b0010; v.regWrite = 1;
        v.f1Rd = 4; v.f1We = 1; v.f1Ld = 1; v.f1Res = 'h5A;
        tbl[5] = FWD ? setExp(v, 0, 0, 'h77, 'h99, 'h99, 4'b0010, 10, 1, 1)
                     : setExp(v, 1, 1, 'h10, 'h40, 'h40, 4'b0010, 9, 1, 0);
        v.f1Ld = 0;
        tbl[6] = setExp(v, 1, 1, 'h10, FWD ? 64'h5A : 64'h40, FWD ? 64'h5A : 64'h40, 4'b0010, 9, 1, FWD ? 16'd1 : 16'd0);
        // Row 7: immediate-form store still stalls on Rm.
        v.aluSrc = 1; v.imm = 8; v.rd = 11; v.regWrite = 0; v.f1Ld = 1;
        tbl[7] = FWD ? setExp(v, 0, 0, 'h10, 'h5A, 'h5A, 4'b0010, 9, 1, 2)
                     : setExp(v, 1, 1, 'h10, 'h8, 'h40, 4'b0010, 11, 0, 0);
        // Row 8: the same match without in_valid is neither a stall nor a capture.
        v.valid = 0;
        tbl[8] = FWD ? setExp(v, 1, 0, 'h10, 'h5A, 'h5A, 4'b0010, 9, 1, 2)
                     : setExp(v, 1, 0, 'h10, 'h8, 'h40, 4'b0010, 11, 0, 0);
        // Row 9: immediate store, Rm from fwd2.
        v = blank(); v.valid = 1; v.aluSrc = 1; v.imm = 'h10; v.rn = 0; v.rm = 2; v.regA = 'hA0; v.regB = 'hB0;
        v.rd = 5; v.ctrl = 4'b0010; v.f2Rd = 2; v.f2We = 1; v.f2Res = 'hAB;
        tbl[9] = setExp(v, 1, 1, 'hA0, 'h10, FWD ? 64'hAB : 64'hB0, 4'b0010, 5, 0, FWD ? 16'd2 : 16'd0);
        // Rows 10-12: back-pressure holds everything; rows 13-14: flush.
        v = blank(); v.valid = 1; v.rn = 1; v.regA = 1; v.regB = 2; v.rd = 7; v.ctrl = 4'b0001; v.regWrite = 1; v.outReady = 0;
        for (int i = 10; i < 13; i++)
            tbl[i] = setExp(v, 0, 1, 'hA0, 'h10, FWD ? 64'hAB : 64'hB0, 4'b0010, 5, 0, FWD ? 16'd2 : 16'd0);
        v.flush = 1;
        tbl[13] = setExp(v, 0, 0, 0, 0, 0, 0, 0, 0, FWD ? 16'd2 : 16'd0); tbl[13].chkData = 0;
        v.outReady = 1;
        tbl[14] = setExp(v, 1, 0, 0, 0, 0, 0, 0, 0, FWD ? 16'd2 : 16'd0); tbl[14].chkData = 0;
        // Rows 15-18: capture, capture while draining, drain, idle.
        v = blank(); v.valid = 1; v.regA = 'h100; v.regB = 'h200; v.rn = 10; v.rm = 11; v.rd = 12; v.ctrl = 4'b0110; v.regWrite = 1;
        tbl[15] = setExp(v, 1, 1, 'h100, 'h200, 'h200, 4'b0110, 12, 1, FWD ? 16'd2 : 16'd0);
        v.regA = 'h300; v.regB = 'h400; v.rd = 13; v.ctrl = 4'b0111;
        tbl[16] = setExp(v, 1, 1, 'h300, 'h400, 'h400, 4'b0111, 13, 1, FWD ? 16'd2 : 16'd0);
        v = blank();
        tbl[17] = setExp(v, 1, 0, 'h300, 'h400, 'h400, 4'b0111, 13, 1, FWD ? 16'd2 : 16'd0);
        v.outReady = 0;
        tbl[18] = setExp(v, 1, 0, 'h300, 'h400, 'h400, 4'b0111, 13, 1, FWD ? 16'd2 : 16'd0);
        // Row 19: load-use on Rn; row 20: a load to XZR is no hazard.
        v = blank(); v.valid = 1; v.rn = 4; v.regA = 1; v.rd = 14; v.ctrl = 4'b0010; v.regWrite = 1;
        v.f1Rd = 4; v.f1We = 1; v.f1Ld = 1; v.f1Res = 'hCC;
        tbl[19] = FWD ? setExp(v, 0, 0, 'h300, 'h400, 'h400, 4'b0111, 13, 1, 3)
                      : setExp(v, 1, 1, 1, 0, 0, 4'b0010, 14, 1, 0);
        v = blank(); v.valid = 1; v.rn = 31; v.rm = 31; v.regA = 5; v.regB = 6; v.rd = 15; v.ctrl = 4'b0010; v.regWrite = 1;
        v.f1Rd = 31; v.f1We = 1; v.f1Ld = 1; v.f1Res = 'hCC;
        tbl[20] = setExp(v, 1, 1, 5, 6, 6, 4'b0010, 15, 1, FWD ? 16'd3 : 16'd0);

        // Reset held with a valid instruction present.
        resetl = 1'b0;
        v = blank(); v.valid = 1; v.regA = 5; v.regB = 7; v.ctrl = 4'b0010; v.rd = 3; v.regWrite = 1;
        drive(v);
        repeat (3) @(posedge CLK);
        #1;
        checkResetState("reset");
        check("reset in_ready", 64'(in_ready), 64'd1);

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            resetl = 1'b1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i].eA);
            #1;
            check($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].eInReady));
            @(posedge CLK);
            #1;
            begin
                logic [63:0] expA;
                expA = exp_q.pop_front();
                check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].eValid));
                check($sformatf("row%0d out_RegWrite", i), 64'(out_RegWrite), 64'(tbl[i].eRw));
                check($sformatf("row%0d stall_count", i), 64'(stall_count), 64'(tbl[i].eStall));
                if (tbl[i].chkData) begin
                    check($sformatf("row%0d BusA", i), BusA, expA);
                    check($sformatf("row%0d BusB", i), BusB, tbl[i].eB);
                    check($sformatf("row%0d out_StoreData", i), out_StoreData, tbl[i].eS);
                    check($sformatf("row%0d ALUCtrl", i), 64'(ALUCtrl), 64'(tbl[i].eCtrl));
                    check($sformatf("row%0d out_Rd", i), 64'(out_Rd), 64'(tbl[i].eRd));
                end
            end
        end

        // Reset asserted between edges clears state immediately and drops the in-flight beat.
        @(negedge CLK);
        v = blank(); v.valid = 1; v.regA = 'h77; v.regB = 'h78; v.rd = 2; v.ctrl = 4'b0010; v.regWrite = 1;
        drive(v);
        resetl = 1'b0;
        #1;
        checkResetState("async reset");
        @(posedge CLK);
        #1;
        check("reset hold out_valid", 64'(out_valid), 64'd0);
        @(negedge CLK);
        resetl = 1'b1;
        v.regA = 'h42; v.regB = 'h43;
        drive(v);
        @(posedge CLK);
        #1;
        check("post-reset out_valid", 64'(out_valid), 64'd1);
        check("post-reset BusA", BusA, 64'h42);
        check("post-reset BusB", BusB, 64'h43);
        check("post-reset ALUCtrl", 64'(ALUCtrl), 64'd2);

        // Final report
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
